// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU issue stage.
//   alu_ctrl_e   - 4-bit ALU operation code driven to EX
//   Op* / Fn*    - MIPS opcode and R-type funct field values handled by decode
//   alu_bundle_t - decoded operand/control bundle held in the issue buffer
//   sext16/zext16 - immediate extension helpers
package alu_pkg;

  typedef enum logic [3:0] {
    AluAnd  = 4'b0000,
    AluOr   = 4'b0001,
    AluAdd  = 4'b0010,
    AluSll  = 4'b0011,
    AluSrl  = 4'b0100,
    AluSub  = 4'b0110,
    AluSlt  = 4'b0111,
    AluAddu = 4'b1000,
    AluSubu = 4'b1001,
    AluXor  = 4'b1010,
    AluSltu = 4'b1011,
    AluNor  = 4'b1100,
    AluSra  = 4'b1101,
    AluLui  = 4'b1110
  } alu_ctrl_e;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnSrav = 6'h07;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  typedef struct packed {
    alu_ctrl_e   alu_ctrl;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic [4:0]  shmt;
    logic [31:0] shift;
    logic        illegal;
  } alu_bundle_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] imm);
    return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// alu_decode: purely combinational MIPS decode into an ALU bundle.
//   i_instr   - instruction word
//   i_rs_data - register rs read value (operand A, variable shift amount)
//   i_rt_data - register rt read value (operand B for R-type and branches)
//   o_bundle  - alu_ctrl, bus_a, bus_b, shmt, shift (= bus_b >> shmt), illegal
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  output alu_bundle_t o_bundle
);

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  alu_ctrl_e   w_ctrl;
  logic [31:0] w_bus_b;
  logic [4:0]  w_shmt;
  logic        w_illegal;

  // Register-number fields are resolved upstream by the register file.
  logic w_unused_instr;
  assign w_unused_instr = ^i_instr[25:16];

  assign w_opcode = i_instr[31:26];
  assign w_funct  = i_instr[5:0];
  assign w_imm    = i_instr[15:0];

  // Defaults are the R-type operand routing, which is also what an
  // undecoded instruction carries downstream.
  always_comb begin
    w_ctrl    = AluAnd;
    w_bus_b   = i_rt_data;
    w_shmt    = 5'd0;
    w_illegal = 1'b0;
    case (w_opcode)
      OpRtype: begin
        case (w_funct)
          FnAdd:  w_ctrl = AluAdd;
          FnAddu: w_ctrl = AluAddu;
          FnSub:  w_ctrl = AluSub;
          FnSubu: w_ctrl = AluSubu;
          FnAnd:  w_ctrl = AluAnd;
          FnOr:   w_ctrl = AluOr;
          FnXor:  w_ctrl = AluXor;
          FnNor:  w_ctrl = AluNor;
          FnSlt:  w_ctrl = AluSlt;
          FnSltu: w_ctrl = AluSltu;
          FnSll:  begin w_ctrl = AluSll; w_shmt = i_instr[10:6];   end
          FnSrl:  begin w_ctrl = AluSrl; w_shmt = i_instr[10:6];   end
          FnSra:  begin w_ctrl = AluSra; w_shmt = i_instr[10:6];   end
          FnSllv: begin w_ctrl = AluSll; w_shmt = i_rs_data[4:0];  end
          FnSrlv: begin w_ctrl = AluSrl; w_shmt = i_rs_data[4:0];  end
          FnSrav: begin w_ctrl = AluSra; w_shmt = i_rs_data[4:0];  end
          default: w_illegal = 1'b1;
        endcase
      end
      OpAddi, OpLw, OpSw: begin w_ctrl = AluAdd;  w_bus_b = sext16(w_imm); end
      OpAddiu:            begin w_ctrl = AluAddu; w_bus_b = sext16(w_imm); end
      OpSlti:             begin w_ctrl = AluSlt;  w_bus_b = sext16(w_imm); end
      OpSltiu:            begin w_ctrl = AluSltu; w_bus_b = sext16(w_imm); end
      OpAndi:             begin w_ctrl = AluAnd;  w_bus_b = zext16(w_imm); end
      OpOri:              begin w_ctrl = AluOr;   w_bus_b = zext16(w_imm); end
      OpXori:             begin w_ctrl = AluXor;  w_bus_b = zext16(w_imm); end
      // The ALU places the immediate in the upper half itself.
      OpLui:              begin w_ctrl = AluLui;  w_bus_b = zext16(w_imm); end
      OpBeq, OpBne:       w_ctrl = AluSub;
      default:            w_illegal = 1'b1;
    endcase
  end

  assign o_bundle = '{
    alu_ctrl: w_ctrl,
    bus_a:    i_rs_data,
    bus_b:    w_bus_b,
    shmt:     w_shmt,
    shift:    w_bus_b >> w_shmt,
    illegal:  w_illegal
  };

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue stage with a 2-entry skid buffer.
//   clk, reset          - clock; asynchronous active-high reset
//   flush               - synchronous discard of buffered and incoming bundles
//   in_valid/in_ready   - upstream handshake (in_ready is registered)
//   instr, rs_data, rt_data - instruction word and register read values
//   out_valid/out_ready - downstream handshake
//   alu_ctrl, bus_a, bus_b, shmt, shift, illegal - head-of-buffer bundle
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] bus_a,
  output logic [31:0] bus_b,
  output logic [4:0]  shmt,
  output logic [31:0] shift,
  output logic        illegal
);

  alu_bundle_t r_mem [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic        r_in_ready;

  alu_bundle_t w_dec;
  alu_bundle_t w_head;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_count_d;

  alu_decode u_decode (
    .i_instr   (instr),
    .i_rs_data (rs_data),
    .i_rt_data (rt_data),
    .o_bundle  (w_dec)
  );

  // r_in_ready is low only when full, so occupancy never exceeds 2.
  assign w_push = in_valid && r_in_ready;
  assign w_pop  = out_valid && out_ready;

  always_comb begin
    w_count_d = r_count;
    if (flush) begin
      w_count_d = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_d = r_count + 2'd1;
        2'b01:   w_count_d = r_count - 2'd1;
        default: w_count_d = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_count_d;
      r_in_ready <= (w_count_d != 2'd2);
      if (flush) begin
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= w_dec;
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
      end
    end
  end

  // Outputs come straight from buffer registers; nothing from the inputs
  // reaches them combinationally.
  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_count != 2'd0);
  assign in_ready  = r_in_ready;
  assign alu_ctrl  = w_head.alu_ctrl;
  assign bus_a     = w_head.bus_a;
  assign bus_b     = w_head.bus_b;
  assign shmt      = w_head.shmt;
  assign shift     = w_head.shift;
  assign illegal   = w_head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed, scoreboard-based bench for alu_issue_stage.
module tb_alu_issue_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] bus_a;
  logic [31:0] bus_b;
  logic [4:0]  shmt;
  logic [31:0] shift;
  logic        illegal;

  alu_issue_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .bus_a     (bus_a),
    .bus_b     (bus_b),
    .shmt      (shmt),
    .shift     (shift),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  instr;
    logic [31:0]  rs;
    logic [31:0]  rt;
    logic [105:0] exp;
  } vec_t;

  localparam int NVec = 15;
  vec_t vecs [NVec];

  logic [105:0] sb_q [$];
  logic [105:0] w_obs;
  int n_cmp = 0;
  int n_err = 0;

  assign w_obs = {alu_ctrl, bus_a, bus_b, shmt, shift, illegal};

  function automatic logic [105:0] mk(input logic [3:0] c, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] sh,
                                      input logic ill);
    return {c, a, b, sh, b >> sh, ill};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic [105:0] obs, input logic [105:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input int i);
    instr   = vecs[i].instr;
    rs_data = vecs[i].rs;
    rt_data = vecs[i].rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb_q.size() != 0 || out_valid) && k < 30) begin
      tick();
      k++;
    end
    chk1("drain_empty", sb_q.size() == 0, 1'b1);
  endtask

  // Scoreboard pop: a transfer happens at the next rising edge whenever
  // out_valid && out_ready hold at the falling edge before it.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      chk1("out_expected", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) chkb("out_bundle", w_obs, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h2008FFFF, 32'h5,   32'h77,       mk(4'b0010, 32'h5, 32'hFFFFFFFF, 5'd0, 1'b0)};
    vecs[1]  = '{32'h00000007, 32'h24,  32'h80000000, mk(4'b1101, 32'h24, 32'h80000000, 5'd4, 1'b0)};
    vecs[2]  = '{32'h3C001234, 32'h11,  32'h0,        mk(4'b1110, 32'h11, 32'h00001234, 5'd0, 1'b0)};
    vecs[3]  = '{32'h34008000, 32'h22,  32'h9,        mk(4'b0001, 32'h22, 32'h00008000, 5'd0, 1'b0)};
    vecs[4]  = '{32'hFC0012C5, 32'h1,   32'h2,        mk(4'b0000, 32'h1, 32'h2, 5'd0, 1'b1)};
    vecs[5]  = '{32'h00000200, 32'hAB,  32'hF000,     mk(4'b0011, 32'hAB, 32'hF000, 5'd8, 1'b0)};
    vecs[6]  = '{32'h10000003, 32'h9,   32'h7,        mk(4'b0110, 32'h9, 32'h7, 5'd0, 1'b0)};
    vecs[7]  = '{32'h8C00FFF0, 32'h100, 32'h5,        mk(4'b0010, 32'h100, 32'hFFFFFFF0, 5'd0, 1'b0)};
    vecs[8]  = '{32'h2C008001, 32'h3,   32'h0,        mk(4'b1011, 32'h3, 32'hFFFF8001, 5'd0, 1'b0)};
    vecs[9]  = '{32'h00000001, 32'h3,   32'h4,        mk(4'b0000, 32'h3, 32'h4, 5'd0, 1'b1)};
    vecs[10] = '{32'h3800FFFF, 32'h55,  32'h1,        mk(4'b1010, 32'h55, 32'h0000FFFF, 5'd0, 1'b0)};
    vecs[11] = '{32'h00000023, 32'h10,  32'h3,        mk(4'b1001, 32'h10, 32'h3, 5'd0, 1'b0)};
    vecs[12] = '{32'h000007C2, 32'h0,   32'h80000000, mk(4'b0100, 32'h0, 32'h80000000, 5'd31, 1'b0)};
    vecs[13] = '{32'h00000004, 32'h23,  32'h1,        mk(4'b0011, 32'h23, 32'h1, 5'd3, 1'b0)};
    vecs[14] = '{32'hAC000004, 32'h8,   32'h6,        mk(4'b0010, 32'h8, 32'h4, 5'd0, 1'b0)};

    // Asynchronous reset, checked before the first clock edge.
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rs_data = '0; rt_data = '0;
    #1 reset = 1'b1;
    #2;
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_in_ready", in_ready, 1'b1);
    chkb("reset_bundle", w_obs, 106'd0);
    tick();
    reset = 1'b0;

    // Single-cycle latency: addi accepted at edge N, visible after it.
    out_ready = 1'b1;
    set_vec(0); in_valid = 1'b1; sb_q.push_back(vecs[0].exp);
    tick();
    chk1("latency_out_valid", out_valid, 1'b1);
    chk1("latency_in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    drain();

    // Full-rate stream of all decode patterns.
    for (int i = 1; i < NVec; i++) begin
      set_vec(i); in_valid = 1'b1; sb_q.push_back(vecs[i].exp);
      tick();
      chk1("stream_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: two accepted, third held upstream until space opens.
    out_ready = 1'b0;
    set_vec(11); in_valid = 1'b1; sb_q.push_back(vecs[11].exp);
    tick();
    chk1("bp_in_ready_1", in_ready, 1'b1);
    chk1("bp_out_valid_1", out_valid, 1'b1);
    set_vec(12); sb_q.push_back(vecs[12].exp);
    tick();
    chk1("bp_in_ready_full", in_ready, 1'b0);
    set_vec(13);
    tick();
    chk1("bp_in_ready_held", in_ready, 1'b0);
    chkb("bp_hold", w_obs, sb_q[0]);
    tick();
    chkb("bp_hold2", w_obs, sb_q[0]);
    out_ready = 1'b1;
    begin
      int k;
      k = 0;
      tick();
      while (!in_ready && k < 8) begin
        tick();
        k++;
      end
      chk1("bp_reopen", in_ready, 1'b1);
    end
    sb_q.push_back(vecs[13].exp);
    tick();
    in_valid = 1'b0;
    drain();

    // Flush with one entry held and an acceptable incoming bundle.
    out_ready = 1'b0;
    set_vec(2); in_valid = 1'b1;
    tick();
    set_vec(3); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk1("flush1_out_valid", out_valid, 1'b0);
    chk1("flush1_in_ready", in_ready, 1'b1);

    // Flush with the buffer full plus an incoming bundle.
    set_vec(4); in_valid = 1'b1;
    tick();
    set_vec(5);
    tick();
    chk1("flush2_full", in_ready, 1'b0);
    set_vec(6); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk1("flush2_out_valid", out_valid, 1'b0);
    chk1("flush2_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("flush2_stays_empty", out_valid, 1'b0);
    end

    // Asynchronous reset while full.
    out_ready = 1'b0;
    set_vec(7); in_valid = 1'b1;
    tick();
    set_vec(8);
    tick();
    in_valid = 1'b0;
    chk1("rst_full_before", out_valid, 1'b1);
    #3 reset = 1'b1;
    #1;
    chk1("rst_async_out_valid", out_valid, 1'b0);
    chk1("rst_async_in_ready", in_ready, 1'b1);
    chkb("rst_async_bundle", w_obs, 106'd0);
    tick();
    reset = 1'b0;

    // Normal operation resumes after reset.
    out_ready = 1'b1;
    set_vec(10); in_valid = 1'b1; sb_q.push_back(vecs[10].exp);
    tick();
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
